// File: rtl/cpu_datapath_pkg.sv
// Shared constants, state/opcode codes and instruction field positions for the
// multi-cycle CPU datapath.
package cpu_datapath_pkg;

  localparam int DATA_BUS_WIDTH    = 32;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int STATE_BITS        = 2;
  localparam int REG_ADDR_BITS     = 5;
  localparam int NUM_REGS          = 1 << REG_ADDR_BITS;

  localparam int OPC_MSB  = 27;
  localparam int OPC_LSB  = 23;
  localparam int RD_MSB   = 22;
  localparam int RD_LSB   = 18;
  localparam int RS_MSB   = 17;
  localparam int RS_LSB   = 13;
  localparam int IMM_MSB  = 17;
  localparam int IMM_LSB  = 0;
  localparam int IMM_BITS = IMM_MSB - IMM_LSB + 1;
  localparam int OPC_BITS = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [STATE_BITS-1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2
  } state_e;

  typedef enum logic [OPC_BITS-1:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_LOADI = 5'd6
  } opcode_e;

  function automatic logic [DATA_BUS_WIDTH-1:0] zext_imm(input logic [IMM_BITS-1:0] imm);
    return {{(DATA_BUS_WIDTH-IMM_BITS){1'b0}}, imm};
  endfunction

  // Unknown opcodes fall through as NOP, so only 1..6 commit a result.
  function automatic logic op_writes_rd(input logic [OPC_BITS-1:0] op);
    return (op >= OP_ADD) && (op <= OP_LOADI);
  endfunction

endpackage

// File: rtl/cpu_datapath_reg_file.sv
// 32-entry register file: two combinational read ports, one synchronous write
// port, r0 hard-wired to zero, synchronous active-low clear.
module reg_file
  import cpu_datapath_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [REG_ADDR_BITS-1:0]  read1_addr_i,
  input  logic [REG_ADDR_BITS-1:0]  read2_addr_i,
  output logic [DATA_BUS_WIDTH-1:0] read1_data_o,
  output logic [DATA_BUS_WIDTH-1:0] read2_data_o,
  input  logic                      write_en_i,
  input  logic [REG_ADDR_BITS-1:0]  write_addr_i,
  input  logic [DATA_BUS_WIDTH-1:0] write_data_i
);

  logic [DATA_BUS_WIDTH-1:0] reg_data [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_data[i] <= '0;
      end
    end else if (write_en_i && (write_addr_i != '0)) begin
      reg_data[write_addr_i] <= write_data_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old value.
  assign read1_data_o = (read1_addr_i == '0) ? '0 : reg_data[read1_addr_i];
  assign read2_data_o = (read2_addr_i == '0) ? '0 : reg_data[read2_addr_i];

endmodule

// File: rtl/cpu_datapath.sv
// Multi-cycle CPU datapath top: control FSM, instruction register, ALU and the
// register file; every instruction runs FETCH -> DECODE -> EXECUTE.
module cpu_datapath
  import cpu_datapath_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_data,
  output logic [STATE_BITS-1:0]        dbg_state,
  output logic [INSTRUCTION_WIDTH-1:0] dbg_instr,
  output logic [DATA_BUS_WIDTH-1:0]    dbg_databus
);

  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic [OPC_BITS-1:0]          aluOP;
  logic [REG_ADDR_BITS-1:0]     read1_addr;
  logic [REG_ADDR_BITS-1:0]     read2_addr;
  logic [DATA_BUS_WIDTH-1:0]    read1_data;
  logic [DATA_BUS_WIDTH-1:0]    read2_data;
  logic [DATA_BUS_WIDTH-1:0]    alu_result;
  logic [DATA_BUS_WIDTH-1:0]    imm_ext;
  logic [DATA_BUS_WIDTH-1:0]    databus;
  logic                         ireg_enable;
  logic                         write_imm;
  logic                         reg_write;
  logic                         exec_phase;

  if (1) begin : control
    state_e state;
    state_e next_state;

    always_ff @(posedge clk) begin
      if (!reset) begin
        state <= FETCH;
      end else begin
        state <= next_state;
      end
    end

    always_comb begin
      next_state  = FETCH;
      ireg_enable = 1'b0;
      reg_write   = 1'b0;
      exec_phase  = 1'b0;
      case (state)
        FETCH: begin
          ireg_enable = 1'b1;
          next_state  = DECODE;
        end
        DECODE: begin
          next_state = EXECUTE;
        end
        EXECUTE: begin
          exec_phase = 1'b1;
          reg_write  = op_writes_rd(aluOP);
          next_state = FETCH;
        end
        default: begin
          next_state = FETCH;
        end
      endcase
    end

    assign dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instruction <= '0;
    end else if (ireg_enable) begin
      instruction <= mem_data;
    end
  end

  assign aluOP      = instruction[OPC_MSB:OPC_LSB];
  assign read1_addr = instruction[RD_MSB:RD_LSB];
  assign read2_addr = instruction[RS_MSB:RS_LSB];
  assign imm_ext    = zext_imm(instruction[IMM_MSB:IMM_LSB]);
  assign write_imm  = (aluOP == OP_LOADI);

  reg_file reg1 (
    .clk_i        (clk),
    .reset_i      (reset),
    .read1_addr_i (read1_addr),
    .read2_addr_i (read2_addr),
    .read1_data_o (read1_data),
    .read2_data_o (read2_data),
    .write_en_i   (reg_write),
    .write_addr_i (read1_addr),
    .write_data_i (databus)
  );

  always_comb begin
    alu_result = '0;
    case (aluOP)
      OP_ADD:  alu_result = read1_data + read2_data;
      OP_SUB:  alu_result = read1_data - read2_data;
      OP_AND:  alu_result = read1_data & read2_data;
      OP_OR:   alu_result = read1_data | read2_data;
      OP_XOR:  alu_result = read1_data ^ read2_data;
      default: alu_result = '0;
    endcase
  end

  // The bus is idle (zero) outside EXECUTE so the debug view only shows results.
  assign databus = exec_phase ? (write_imm ? imm_ext : alu_result) : '0;

  assign dbg_instr   = instruction;
  assign dbg_databus = databus;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath with a behavioural instruction-level model
// checked after every clock edge, plus hand-computed literal expectations.
module tb_cpu_datapath;

  logic        clk;
  logic        reset;
  logic [31:0] mem_data;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_instr;
  logic [31:0] dbg_databus;

  int total;
  int bad;

  int          ph;
  logic [31:0] m_ir;
  logic [31:0] m_regs [32];

  cpu_datapath dut (
    .clk         (clk),
    .reset       (reset),
    .mem_data    (mem_data),
    .dbg_state   (dbg_state),
    .dbg_instr   (dbg_instr),
    .dbg_databus (dbg_databus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int f_op(input logic [31:0] ir);
    return int'((ir >> 23) & 32'h1f);
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] ir);
    logic [31:0] a;
    logic [31:0] b;
    a = m_regs[(ir >> 18) & 32'h1f];
    b = m_regs[(ir >> 13) & 32'h1f];
    case (f_op(ir))
      1:       return a + b;
      2:       return a - b;
      3:       return a & b;
      4:       return a | b;
      5:       return a ^ b;
      6:       return ir & 32'h0003ffff;
      default: return 32'h0;
    endcase
  endfunction

  // Advances the model by one clock using the inputs that the edge will sample.
  task automatic model_update();
    int rd;
    if (!reset) begin
      ph   = 0;
      m_ir = 32'h0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else if (ph == 0) begin
      m_ir = mem_data;
      ph   = 1;
    end else if (ph == 1) begin
      ph = 2;
    end else begin
      rd = int'((m_ir >> 18) & 32'h1f);
      if (f_op(m_ir) >= 1 && f_op(m_ir) <= 6 && rd != 0) m_regs[rd] = model_result(m_ir);
      ph = 0;
    end
  endtask

  task automatic compare();
    check("state", {30'h0, dbg_state}, ph[31:0]);
    check("instr", dbg_instr, m_ir);
    if (ph == 2 && f_op(m_ir) >= 1 && f_op(m_ir) <= 6)
      check("databus", dbg_databus, model_result(m_ir));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare();
  endtask

  // FETCH and DECODE edges; mem_data is scrambled once the word has been fetched.
  task automatic fetch_decode(input logic [31:0] word);
    reset    = 1'b1;
    mem_data = word;
    step();
    mem_data = $urandom;
    step();
    mem_data = $urandom;
  endtask

  task automatic run_instr(input logic [31:0] word);
    fetch_decode(word);
    step();
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int imm);
    logic [31:0] w;
    w = (32'(op) << 23) | (32'(rd) << 18);
    if (op == 6) w = w | (32'(imm) & 32'h0003ffff);
    else         w = w | (32'(rs) << 13);
    return w;
  endfunction

  initial begin
    total    = 0;
    bad      = 0;
    ph       = 0;
    m_ir     = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    reset    = 1'b0;
    mem_data = 32'hdead_beef;

    repeat (3) step();
    check("rst_state", {30'h0, dbg_state}, 32'd0);
    check("rst_instr", dbg_instr, 32'h0);
    check("rst_databus", dbg_databus, 32'h0);

    run_instr(32'h0304_0014);
    check("loadi_r1_instr", dbg_instr, 32'h0304_0014);
    check("loadi_r1_state", {30'h0, dbg_state}, 32'd0);
    run_instr(32'h0308_0016);

    fetch_decode(32'h0088_2000);
    check("add_exec_state", {30'h0, dbg_state}, 32'd2);
    check("add_exec_bus", dbg_databus, 32'd42);
    step();
    fetch_decode(32'h0088_0000);
    check("r2_after_add", dbg_databus, 32'd42);
    step();
    fetch_decode(32'h0084_0000);
    check("r1_still_20", dbg_databus, 32'd20);
    step();

    // Reset while in DECODE abandons the in-flight LOADI r3.
    reset    = 1'b1;
    mem_data = 32'h030C_0007;
    step();
    reset = 1'b0;
    step();
    check("mid_rst_state", {30'h0, dbg_state}, 32'd0);
    check("mid_rst_instr", dbg_instr, 32'h0);
    fetch_decode(32'h0084_0000);
    check("r1_cleared", dbg_databus, 32'h0);
    step();
    fetch_decode(32'h008C_0000);
    check("r3_not_written", dbg_databus, 32'h0);
    step();

    run_instr(32'h0300_0005);
    run_instr(32'h0304_0009);
    fetch_decode(32'h0084_0000);
    check("r0_stays_zero", dbg_databus, 32'd9);
    step();

    run_instr(32'h0F84_2000);
    fetch_decode(32'h0084_0000);
    check("op31_no_write", dbg_databus, 32'd9);
    step();

    run_instr(32'h0308_0005);
    fetch_decode(32'h0108_2000);
    check("sub_wrap", dbg_databus, 32'hFFFF_FFFC);
    step();

    for (int k = 0; k < 6; k++) run_instr(enc(6, k + 1, 0, int'($urandom_range(0, 32'h3ffff))));
    for (int k = 0; k < 60; k++) begin
      int op;
      op = (k % 8 < 6) ? (k % 6) + 1 : int'($urandom_range(7, 31));
      run_instr(enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 32'h3ffff))));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
